spi_tx_engine: RTL and testbench

SPI_TX_ENGINE -- requirements
Module: spi_tx_engine

---
 rtl/spi_tx_engine_pkg.sv | 11 +
 rtl/spi_tx_engine_if.sv | 17 +
 rtl/spi_piso_shift.sv | 21 ++
 rtl/spi_tx_engine.sv | 89 ++++++++
 tb/tb_spi_tx_engine.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_tx_engine_pkg.sv
// spi_tx_engine_pkg: shared FSM encoding and default sizing for the SPI transmitter
package spi_tx_engine_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;
  localparam int LARGO_DEF = 8;
  localparam int DIV_DEF = 2;
endpackage

// File: rtl/spi_tx_engine_if.sv
// spi_tx_engine_if: word handshake plus SPI pins of the transmitter
interface spi_tx_engine_if
  import spi_tx_engine_pkg::*;
#(
  parameter int LARGO = LARGO_DEF
);
  logic tx_valid;
  logic tx_ready;
  logic [LARGO-1:0] tx_data;
  logic sclk;
  logic mosi;
  logic cs_n;
  logic busy;
  logic done;
  modport master (output tx_valid, tx_data, input tx_ready, sclk, mosi, cs_n, busy, done);
  modport slave (input tx_valid, tx_data, output tx_ready, sclk, mosi, cs_n, busy, done);
endinterface

// File: rtl/spi_piso_shift.sv
// spi_piso_shift: parallel-load, shift-left register; exposes the MSB it will hold next cycle
module spi_piso_shift
  import spi_tx_engine_pkg::*;
#(
  parameter int LARGO = LARGO_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [LARGO-1:0] i_data,
  output logic             o_msb_next
);
  logic [LARGO-1:0] r_sr;
  logic [LARGO-1:0] w_sr;
  assign w_sr = i_load ? i_data : i_shift ? {r_sr[LARGO-2:0], 1'b0} : r_sr;
  assign o_msb_next = w_sr[LARGO-1];
  always_ff @(posedge clk or posedge rst)
    if (rst) r_sr <= '0;
    else r_sr <= w_sr;
endmodule

// File: rtl/spi_tx_engine.sv
// spi_tx_engine: SPI transmitter sending one MSB-first word per cs_n frame, sclk idle low
module spi_tx_engine
  import spi_tx_engine_pkg::*;
#(
  parameter int LARGO = LARGO_DEF,
  parameter int DIV = DIV_DEF
) (
  input logic           clk,
  input logic           rst,
  spi_tx_engine_if.slave bus
);
  localparam int DW = $clog2(DIV + 1);
  localparam int BW = $clog2(LARGO + 1);
  state_t r_state;
  state_t w_nxt;
  logic [DW-1:0] r_div;
  logic [DW-1:0] w_div;
  logic [BW-1:0] r_bit;
  logic [BW-1:0] w_bit;
  logic r_hi, w_hi;
  logic w_end, w_load, w_shift, w_msb_next;
  logic r_sclk, r_mosi, r_cs_n, r_busy, r_done;
  logic w_sclk, w_mosi, w_cs_n, w_done;

  assign w_end = r_div == DW'(DIV - 1);
  assign w_load = r_state == IDLE && bus.tx_valid;
  assign w_shift = r_state == SHIFT && !r_hi && w_end;
  assign bus.tx_ready = r_state == IDLE && !rst;
  assign bus.sclk = r_sclk;
  assign bus.mosi = r_mosi;
  assign bus.cs_n = r_cs_n;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

  spi_piso_shift #(.LARGO(LARGO)) u_piso (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_shift   (w_shift),
    .i_data    (bus.tx_data),
    .o_msb_next(w_msb_next)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_div <= '0;
      r_bit <= '0;
      r_hi <= 1'b0;
      r_sclk <= 1'b0;
      r_mosi <= 1'b0;
      r_cs_n <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_div <= w_div;
      r_bit <= w_bit;
      r_hi <= w_hi;
      r_sclk <= w_sclk;
      r_mosi <= w_mosi;
      r_cs_n <= w_cs_n;
      r_busy <= !w_cs_n;
      r_done <= w_done;
    end

  // r_hi selects the sclk-high half of a bit; the register shifts only when a low half ends
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = bus.tx_valid ? SETUP : IDLE;
      SETUP:   w_nxt = w_end ? SHIFT : SETUP;
      SHIFT:   w_nxt = w_shift && r_bit == BW'(LARGO - 1) ? HOLD : SHIFT;
      HOLD:    w_nxt = w_end ? IDLE : HOLD;
      default: w_nxt = IDLE;
    endcase
    w_div = r_state == IDLE || w_end ? '0 : r_div + DW'(1);
    w_hi = r_state != SHIFT || (w_end ? !r_hi : r_hi);
    w_bit = r_state == IDLE ? '0 : r_bit + BW'(w_shift);
  end

  // outputs are decoded from next-state values so the registered pins line up with the state
  always_comb begin
    w_cs_n = w_nxt == IDLE;
    w_sclk = w_nxt == SHIFT && w_hi;
    w_mosi = w_nxt == SHIFT && w_msb_next;
    w_done = r_state == HOLD && w_nxt == IDLE;
  end
endmodule

// File: tb/tb_spi_tx_engine.sv
// tb_spi_tx_engine: frame-timing model checks an 8b/DIV2 and a 2b/DIV1 engine every cycle
module tb_spi_tx_engine;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [1:0] i_v = '0;
  logic [7:0] i_d [2] = '{8'h00, 8'h00};
  always #5 clk = ~clk;

  spi_tx_engine_if #(.LARGO(8)) a_if ();
  spi_tx_engine_if #(.LARGO(2)) b_if ();
  spi_tx_engine #(.LARGO(8), .DIV(2)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  spi_tx_engine #(.LARGO(2), .DIV(1)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

  assign a_if.tx_valid = i_v[0];
  assign a_if.tx_data = i_d[0];
  assign b_if.tx_valid = i_v[1];
  assign b_if.tx_data = i_d[1][1:0];

  logic [1:0] o_cs, o_sc, o_mo, o_bz, o_dn, o_rd;
  assign o_cs = {b_if.cs_n, a_if.cs_n};
  assign o_sc = {b_if.sclk, a_if.sclk};
  assign o_mo = {b_if.mosi, a_if.mosi};
  assign o_bz = {b_if.busy, a_if.busy};
  assign o_dn = {b_if.done, a_if.done};
  assign o_rd = {b_if.tx_ready, a_if.tx_ready};

  function automatic int dv(int i); return i == 0 ? 2 : 1; endfunction
  function automatic int lg(int i); return i == 0 ? 8 : 2; endfunction
  function automatic int frame(int i); return dv(i) * (2 * lg(i) + 2); endfunction
  function automatic logic [7:0] msk(int i); return i == 0 ? 8'hFF : 8'h03; endfunction

  // k counts cycles since the handshake edge; bits start after DIV setup cycles
  function automatic logic e_sclk(int i, int k);
    int b = k - dv(i);
    return b >= 0 && b < 2 * lg(i) * dv(i) && (b / dv(i)) % 2 == 0;
  endfunction
  function automatic logic e_mosi(int i, int k, logic [7:0] w);
    int b = k - dv(i);
    if (b < 0 || b >= 2 * lg(i) * dv(i)) return 1'b0;
    return w[lg(i) - 1 - b / (2 * dv(i))];
  endfunction

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0b want %0b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic m_act [2];
  int m_k [2];
  logic [7:0] m_w [2];
  logic m_dn [2];
  always @(posedge clk or posedge rst)
    for (int i = 0; i < 2; i++)
      if (rst) begin
        m_act[i] <= 1'b0;
        m_k[i] <= 0;
        m_w[i] <= '0;
        m_dn[i] <= 1'b0;
      end else begin
        m_dn[i] <= m_act[i] && m_k[i] == frame(i) - 1;
        if (m_act[i]) begin
          m_k[i] <= m_k[i] + 1;
          if (m_k[i] == frame(i) - 1) m_act[i] <= 1'b0;
        end else if (i_v[i]) begin
          m_act[i] <= 1'b1;
          m_k[i] <= 0;
          m_w[i] <= i_d[i] & msk(i);
        end
      end

  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      chk1($sformatf("cs_n%0d", i), o_cs[i], !m_act[i]);
      chk1($sformatf("busy%0d", i), o_bz[i], m_act[i]);
      chk1($sformatf("done%0d", i), o_dn[i], m_dn[i]);
      chk1($sformatf("ready%0d", i), o_rd[i], !m_act[i] && !rst);
      chk1($sformatf("sclk%0d", i), o_sc[i], m_act[i] && e_sclk(i, m_k[i]));
      chk1($sformatf("mosi%0d", i), o_mo[i], m_act[i] && e_mosi(i, m_k[i], m_w[i]));
    end

  logic [1:0] p_sc, p_cs;
  int lo_n [2], hi_n [2], lo_last [2], gap_last [2], dn_n [2];
  logic [7:0] rx [2], rx_last [2];
  logic [7:0] b_sc_pat, b_mo_pat;
  always @(negedge clk)
    for (int i = 0; i < 2; i++)
      if (rst) begin
        p_sc[i] <= 1'b0;
        p_cs[i] <= 1'b1;
        lo_n[i] <= 0;
        hi_n[i] <= 0;
        rx[i] <= '0;
      end else begin
        p_sc[i] <= o_sc[i];
        p_cs[i] <= o_cs[i];
        dn_n[i] <= dn_n[i] + int'(o_dn[i]);
        lo_n[i] <= o_cs[i] ? lo_n[i] : lo_n[i] + 1;
        hi_n[i] <= o_cs[i] ? hi_n[i] + 1 : hi_n[i];
        if (p_sc[i] && !o_sc[i]) rx[i] <= {rx[i][6:0], o_mo[i]};
        if (p_cs[i] && !o_cs[i]) begin
          gap_last[i] <= hi_n[i];
          hi_n[i] <= 0;
          lo_n[i] <= 1;
          rx[i] <= '0;
        end
        if (!p_cs[i] && o_cs[i]) begin
          chk($sformatf("frame_len%0d", i), lo_n[i], frame(i));
          chk($sformatf("loopback%0d", i), int'(rx[i]), int'(m_w[i]));
          lo_last[i] <= lo_n[i];
          rx_last[i] <= rx[i];
          hi_n[i] <= 1;
        end
      end

  always @(negedge clk)
    if (!o_cs[1]) begin
      b_sc_pat <= {b_sc_pat[6:0], o_sc[1]};
      b_mo_pat <= {b_mo_pat[6:0], o_mo[1]};
    end

  task automatic send(int i, logic [7:0] w, bit hold);
    int n = 0;
    i_d[i] = w;
    i_v[i] = 1'b1;
    while (!o_rd[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk1("ready_wait", n < 200, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) i_v[i] = 1'b0;
  endtask

  task automatic wait_done(int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_dn[i] && n < 200);
    chk1("done_wait", o_dn[i], 1'b1);
  endtask

  int n, rises, rdy_hi, d0, sel;
  logic ps;
  initial begin
    #1 rst = 1'b1;
    #3;
    chk1("rst_cs_n", o_cs[0], 1'b1);
    chk1("rst_sclk", o_sc[0], 1'b0);
    chk1("rst_mosi", o_mo[0], 1'b0);
    chk1("rst_busy", o_bz[0], 1'b0);
    chk1("rst_ready", o_rd[0], 1'b0);
    chk1("rst_cs_n_b", o_cs[1], 1'b1);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 chk1("ready_after_rst", o_rd[0], 1'b1);

    d0 = dn_n[0];
    send(0, 8'hA5, 1'b0);
    wait_done(0);
    @(posedge clk);
    #1;
    chk("a5_rx", int'(rx_last[0]), 'hA5);
    chk("a5_cs_low", lo_last[0], 36);
    repeat (2) @(negedge clk);
    #1 chk("a5_done_cnt", dn_n[0] - d0, 1);

    send(0, 8'h3C, 1'b1);
    i_d[0] = 8'hC3;
    wait_done(0);
    @(posedge clk);
    #1;
    i_v[0] = 1'b0;
    chk("b2b_first", int'(rx_last[0]), 'h3C);
    wait_done(0);
    @(posedge clk);
    #1;
    chk("b2b_second", int'(rx_last[0]), 'hC3);
    chk("b2b_gap", gap_last[0], 1);

    send(0, 8'h00, 1'b0);
    repeat (6) @(negedge clk);
    i_d[0] = 8'hFF;
    i_v[0] = 1'b1;
    n = 0;
    rdy_hi = 0;
    while (!o_dn[0] && n < 200) begin
      rdy_hi += int'(o_rd[0]);
      @(negedge clk);
      n++;
    end
    i_v[0] = 1'b0;
    chk1("ignore_done", o_dn[0], 1'b1);
    chk("ignore_ready", rdy_hi, 0);
    @(posedge clk);
    #1 chk("ignore_rx", int'(rx_last[0]), 'h00);

    send(0, 8'h81, 1'b0);
    n = 0;
    rises = 0;
    ps = 1'b0;
    while (rises < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (o_sc[0] && !ps) rises++;
      ps = o_sc[0];
    end
    chk("rst_mid_rises", rises, 3);
    d0 = dn_n[0];
    #2 rst = 1'b1;
    #1;
    chk1("mid_rst_cs_n", o_cs[0], 1'b1);
    chk1("mid_rst_sclk", o_sc[0], 1'b0);
    chk1("mid_rst_mosi", o_mo[0], 1'b0);
    chk1("mid_rst_busy", o_bz[0], 1'b0);
    chk1("mid_rst_done", o_dn[0], 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("mid_rst_no_done", dn_n[0] - d0, 0);
    send(0, 8'h81, 1'b0);
    wait_done(0);
    @(posedge clk);
    #1 chk("after_rst_rx", int'(rx_last[0]), 'h81);

    send(1, 8'h02, 1'b0);
    wait_done(1);
    @(posedge clk);
    #1;
    chk("corner_rx", int'(rx_last[1]), 'h2);
    chk("corner_cs_low", lo_last[1], 6);
    chk("corner_sclk_pat", int'(b_sc_pat & 8'h3F), 'h14);
    chk("corner_mosi_pat", int'(b_mo_pat & 8'h3F), 'h18);

    for (int r = 0; r < 40; r++) begin
      sel = int'($urandom_range(0, 1));
      send(sel, 8'($urandom) & msk(sel), 1'b0);
      wait_done(sel);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
